// File: rtl/axi_write_beat_addr_gen.sv
// Purpose: AXI write pass-through that generates per-beat byte address/size, wlast and a sticky protocol error flag.
// Latency: zero added cycles on AW, W and B; one burst in flight, new AW accepted the cycle after the final W beat.
// Backpressure: ready/valid propagated combinationally; W held off (never dropped) until its AW is accepted.
module axi_write_beat_addr_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,

    input  logic [31:0]           u_axi_awaddr,
    input  logic [2:0]            u_axi_awsize,
    input  logic [7:0]            u_axi_awlen,
    input  logic [1:0]            u_axi_awburst,
    input  logic                  u_axi_awvalid,
    output logic                  u_axi_awready,

    input  logic [DATA_WIDTH-1:0] u_axi_wdata,
    input  logic [DATA_BYTES-1:0] u_axi_wstrb,
    input  logic                  u_axi_wlast,
    input  logic                  u_axi_wvalid,
    output logic                  u_axi_wready,

    output logic [31:0]           d_axi_awaddr,
    output logic [2:0]            d_axi_awsize,
    output logic [7:0]            d_axi_awlen,
    output logic [1:0]            d_axi_awburst,
    output logic                  d_axi_awvalid,
    input  logic                  d_axi_awready,

    output logic [DATA_WIDTH-1:0] d_axi_wdata,
    output logic [DATA_BYTES-1:0] d_axi_wstrb,
    output logic                  d_axi_wlast,
    output logic                  d_axi_wvalid,
    input  logic                  d_axi_wready,

    output logic [31:0]           d_axi_waddr,
    output logic [2:0]            d_axi_wsize,

    output logic [1:0]            u_axi_bresp,
    output logic                  u_axi_bvalid,
    input  logic                  u_axi_bready,
    input  logic [1:0]            d_axi_bresp,
    input  logic                  d_axi_bvalid,
    output logic                  d_axi_bready,

    output logic                  err_sticky
);

    // Largest legal awsize for this data width (log2 of the byte lanes).
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_BYTES));

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  beat_cnt;
    logic [31:0] cur_addr;
    logic [2:0]  lat_size;
    logic [7:0]  lat_len;
    logic [1:0]  lat_burst;
    logic        err_q;

    logic        aw_hs;
    logic        w_hs;
    logic        gen_last;
    logic        aw_err;
    logic        last_err;

    logic [31:0] size_bytes;
    logic [31:0] aligned_addr;
    logic [31:0] incr_addr;
    logic [31:0] wrap_bytes;
    logic [31:0] wrap_mask;
    logic [31:0] wrap_addr;
    logic [31:0] next_addr;

    // WRAP bursts are only meaningful for 2, 4, 8 or 16 beats.
    function automatic logic is_wrap_len(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    assign aw_hs    = (state_q == IDLE) && u_axi_awvalid && d_axi_awready;
    assign w_hs     = (state_q == DATA) && u_axi_wvalid && d_axi_wready;
    assign gen_last = (state_q == DATA) && (beat_cnt == lat_len);

    // Bad size, reserved burst type or illegal WRAP length are flagged when the AW is accepted.
    assign aw_err   = (u_axi_awsize > MAX_SIZE) || (u_axi_awburst == 2'b11) ||
                      ((u_axi_awburst == 2'b10) && !is_wrap_len(u_axi_awlen));
    assign last_err = w_hs && (u_axi_wlast != gen_last);

    // Next beat address: FIXED holds, INCR steps from the size-aligned address, WRAP folds into the wrap window.
    always_comb begin
        size_bytes   = 32'd1 << lat_size;
        aligned_addr = cur_addr & ~(size_bytes - 32'd1);
        incr_addr    = aligned_addr + size_bytes;
        wrap_bytes   = ({24'd0, lat_len} + 32'd1) << lat_size;
        wrap_mask    = wrap_bytes - 32'd1;
        wrap_addr    = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
        next_addr    = incr_addr;
        case (lat_burst)
            2'b00:   next_addr = cur_addr;
            2'b10:   next_addr = is_wrap_len(lat_len) ? wrap_addr : incr_addr;
            default: next_addr = incr_addr;
        endcase
    end

    // Channel gating and next-state: AW open only in IDLE, W open only in DATA.
    always_comb begin
        state_d       = state_q;
        d_axi_awvalid = 1'b0;
        u_axi_awready = 1'b0;
        d_axi_wvalid  = 1'b0;
        u_axi_wready  = 1'b0;
        case (state_q)
            IDLE: begin
                d_axi_awvalid = u_axi_awvalid;
                u_axi_awready = d_axi_awready;
                if (aw_hs) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                d_axi_wvalid = u_axi_wvalid;
                u_axi_wready = d_axi_wready;
                if (w_hs && gen_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst context: latch AW fields on acceptance, advance beat counter and address per W beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_cnt  <= 8'd0;
            cur_addr  <= 32'd0;
            lat_size  <= 3'd0;
            lat_len   <= 8'd0;
            lat_burst <= 2'd0;
        end else if (aw_hs) begin
            beat_cnt  <= 8'd0;
            cur_addr  <= u_axi_awaddr;
            lat_size  <= u_axi_awsize;
            lat_len   <= u_axi_awlen;
            lat_burst <= u_axi_awburst;
        end else if (w_hs) begin
            beat_cnt  <= beat_cnt + 8'd1;
            cur_addr  <= next_addr;
        end
    end

    // Sticky protocol error; only reset clears it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if ((aw_hs && aw_err) || last_err) begin
            err_q <= 1'b1;
        end
    end

    assign d_axi_awaddr  = u_axi_awaddr;
    assign d_axi_awsize  = u_axi_awsize;
    assign d_axi_awlen   = u_axi_awlen;
    assign d_axi_awburst = u_axi_awburst;

    assign d_axi_wdata   = u_axi_wdata;
    assign d_axi_wstrb   = u_axi_wstrb;
    assign d_axi_wlast   = gen_last;

    assign d_axi_waddr   = cur_addr;
    assign d_axi_wsize   = lat_size;

    assign u_axi_bresp   = d_axi_bresp;
    assign u_axi_bvalid  = d_axi_bvalid;
    assign d_axi_bready  = u_axi_bready;

    assign err_sticky    = err_q;

endmodule

// File: tb/tb_axi_write_beat_addr_gen.sv
// Purpose: self-checking bench for axi_write_beat_addr_gen against a closed-form address/error model.
// Latency: checks zero-latency pass-through and the one-cycle turnaround between bursts.
// Backpressure: exercises early W, toggling d_axi_wready and random wvalid gaps.
module tb_axi_write_beat_addr_gen;
    localparam int DW = 64;
    localparam int DB = DW / 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [31:0]   u_axi_awaddr;
    logic [2:0]    u_axi_awsize;
    logic [7:0]    u_axi_awlen;
    logic [1:0]    u_axi_awburst;
    logic          u_axi_awvalid;
    logic          u_axi_awready;
    logic [DW-1:0] u_axi_wdata;
    logic [DB-1:0] u_axi_wstrb;
    logic          u_axi_wlast;
    logic          u_axi_wvalid;
    logic          u_axi_wready;
    logic [31:0]   d_axi_awaddr;
    logic [2:0]    d_axi_awsize;
    logic [7:0]    d_axi_awlen;
    logic [1:0]    d_axi_awburst;
    logic          d_axi_awvalid;
    logic          d_axi_awready;
    logic [DW-1:0] d_axi_wdata;
    logic [DB-1:0] d_axi_wstrb;
    logic          d_axi_wlast;
    logic          d_axi_wvalid;
    logic          d_axi_wready;
    logic [31:0]   d_axi_waddr;
    logic [2:0]    d_axi_wsize;
    logic [1:0]    u_axi_bresp;
    logic          u_axi_bvalid;
    logic          u_axi_bready;
    logic [1:0]    d_axi_bresp;
    logic          d_axi_bvalid;
    logic          d_axi_bready;
    logic          err_sticky;

    int vec  = 0;
    int miss = 0;

    // Observations collected at each W handshake.
    logic [31:0]   obs_addr[$];
    logic          obs_last[$];
    logic [2:0]    obs_size[$];
    logic [DW-1:0] obs_data[$];
    logic [DB-1:0] obs_strb[$];
    logic [DW-1:0] sent_data[$];
    logic [DB-1:0] sent_strb[$];
    int            stall_viol;
    logic          aw_dval;
    logic [44:0]   aw_dpay;
    bit            timeout;

    axi_write_beat_addr_gen #(.DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .u_axi_awaddr(u_axi_awaddr), .u_axi_awsize(u_axi_awsize), .u_axi_awlen(u_axi_awlen),
        .u_axi_awburst(u_axi_awburst), .u_axi_awvalid(u_axi_awvalid), .u_axi_awready(u_axi_awready),
        .u_axi_wdata(u_axi_wdata), .u_axi_wstrb(u_axi_wstrb), .u_axi_wlast(u_axi_wlast),
        .u_axi_wvalid(u_axi_wvalid), .u_axi_wready(u_axi_wready),
        .d_axi_awaddr(d_axi_awaddr), .d_axi_awsize(d_axi_awsize), .d_axi_awlen(d_axi_awlen),
        .d_axi_awburst(d_axi_awburst), .d_axi_awvalid(d_axi_awvalid), .d_axi_awready(d_axi_awready),
        .d_axi_wdata(d_axi_wdata), .d_axi_wstrb(d_axi_wstrb), .d_axi_wlast(d_axi_wlast),
        .d_axi_wvalid(d_axi_wvalid), .d_axi_wready(d_axi_wready),
        .d_axi_waddr(d_axi_waddr), .d_axi_wsize(d_axi_wsize),
        .u_axi_bresp(u_axi_bresp), .u_axi_bvalid(u_axi_bvalid), .u_axi_bready(u_axi_bready),
        .d_axi_bresp(d_axi_bresp), .d_axi_bvalid(d_axi_bvalid), .d_axi_bready(d_axi_bready),
        .err_sticky(err_sticky)
    );

    always #5 aclk = ~aclk;

    function automatic bit legal_wrap(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Address of beat i, computed directly from the burst description.
    function automatic logic [31:0] model_addr(input logic [31:0] addr, input logic [2:0] size,
                                               input logic [7:0] len, input logic [1:0] burst, input int i);
        longint unsigned a, sb, al, w, lower, off;
        a  = addr;
        sb = longint'(1) << size;
        al = a - (a % sb);
        if (i == 0 || burst == 2'b00) return addr;
        if (burst == 2'b10 && legal_wrap(len)) begin
            w     = (longint'(len) + 1) * sb;
            lower = a - (a % w);
            off   = ((al % w) + longint'(i) * sb) % w;
            return 32'(lower + off);
        end
        return 32'(al + longint'(i) * sb);
    endfunction

    function automatic logic model_err(input logic [2:0] size, input logic [7:0] len,
                                       input logic [1:0] burst, input bit bad_last);
        return (size > 3'd3) || (burst == 2'b11) || (burst == 2'b10 && !legal_wrap(len)) || bad_last;
    endfunction

    task automatic pulse_reset();
        @(negedge aclk);
        u_axi_awvalid = 1'b0;
        u_axi_wvalid  = 1'b0;
        aresetn       = 1'b0;
        @(negedge aclk);
        aresetn       = 1'b1;
    endtask

    // Drives one AW and len+1 W beats (no comparisons); records what the DUT presents at each handshake.
    task automatic run_burst(input logic [31:0] addr, input logic [2:0] size, input logic [7:0] len,
                             input logic [1:0] burst, input int bad_beat, input int w_lead, input bit toggle);
        int            beat = 0;
        int            cyc  = 0;
        bit            aw_pend = 1'b1;
        bit            w_on = 1'b0;
        logic [DW-1:0] dat;
        logic [DB-1:0] stb;
        obs_addr.delete(); obs_last.delete(); obs_size.delete(); obs_data.delete();
        obs_strb.delete(); sent_data.delete(); sent_strb.delete();
        stall_viol = 0; aw_dval = 1'b0; aw_dpay = '0; timeout = 1'b0;
        dat = {$urandom, $urandom};
        stb = DB'($urandom);
        while ((aw_pend || beat <= int'(len)) && cyc < 600) begin
            @(negedge aclk);
            u_axi_awvalid = aw_pend && (cyc >= w_lead);
            u_axi_awaddr  = addr;
            u_axi_awsize  = size;
            u_axi_awlen   = len;
            u_axi_awburst = burst;
            if (!w_on && beat <= int'(len)) w_on = (w_lead > 0) || ($urandom_range(0, 3) != 0);
            u_axi_wvalid  = w_on;
            u_axi_wdata   = dat;
            u_axi_wstrb   = stb;
            u_axi_wlast   = (beat == int'(len)) ^ (beat == bad_beat);
            d_axi_wready  = toggle ? ~d_axi_wready : 1'b1;
            #1;
            if (aw_pend && u_axi_wready) stall_viol++;
            if (u_axi_awvalid && u_axi_awready) begin
                aw_pend = 1'b0;
                aw_dval = d_axi_awvalid;
                aw_dpay = {d_axi_awaddr, d_axi_awsize, d_axi_awlen, d_axi_awburst};
            end
            if (u_axi_wvalid && u_axi_wready) begin
                obs_addr.push_back(d_axi_waddr);
                obs_last.push_back(d_axi_wlast);
                obs_size.push_back(d_axi_wsize);
                obs_data.push_back(d_axi_wdata);
                obs_strb.push_back(d_axi_wstrb);
                sent_data.push_back(dat);
                sent_strb.push_back(stb);
                beat++;
                w_on = 1'b0;
                dat  = {$urandom, $urandom};
                stb  = DB'($urandom);
            end
            cyc++;
        end
        if (cyc >= 600) timeout = 1'b1;
        @(negedge aclk);
        u_axi_awvalid = 1'b0;
        u_axi_wvalid  = 1'b0;
        d_axi_wready  = 1'b1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        u_axi_awvalid = 1'b0; u_axi_wvalid = 1'b1; u_axi_wlast = 1'b0;
        u_axi_awaddr = 32'h0; u_axi_awsize = 3'd0; u_axi_awlen = 8'd0; u_axi_awburst = 2'b01;
        u_axi_wdata = '0; u_axi_wstrb = '0;
        d_axi_awready = 1'b1; d_axi_wready = 1'b1;
        u_axi_bready = 1'b0; d_axi_bresp = 2'b00; d_axi_bvalid = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        vec++; if (d_axi_waddr !== 32'h0) begin miss++; $display("FAIL reset_waddr: got %h exp 0", d_axi_waddr); end
        vec++; if (d_axi_wsize !== 3'd0) begin miss++; $display("FAIL reset_wsize: got %0d exp 0", d_axi_wsize); end
        vec++; if (err_sticky !== 1'b0) begin miss++; $display("FAIL reset_err: got %b exp 0", err_sticky); end
        vec++; if ({u_axi_wready, d_axi_wvalid, d_axi_wlast} !== 3'b000) begin
            miss++; $display("FAIL reset_wchan: got %b exp 000", {u_axi_wready, d_axi_wvalid, d_axi_wlast});
        end
        vec++; if (u_axi_awready !== 1'b1) begin miss++; $display("FAIL reset_awready: got %b exp 1", u_axi_awready); end
        @(negedge aclk);
        u_axi_wvalid = 1'b0;
        aresetn = 1'b1;
    endtask

    task automatic test_incr();
        logic [31:0] exp_a[4];
        exp_a = '{32'h1004, 32'h1008, 32'h100C, 32'h1010};
        run_burst(32'h1004, 3'd2, 8'd3, 2'b01, -1, 0, 1'b0);
        vec++; if (timeout || obs_addr.size() != 4) begin miss++; $display("FAIL incr_beats: got %0d exp 4", obs_addr.size()); end
        vec++; if (aw_dval !== 1'b1 || aw_dpay !== {32'h1004, 3'd2, 8'd3, 2'b01}) begin
            miss++; $display("FAIL incr_aw_pass: got %b/%h exp 1/%h", aw_dval, aw_dpay, {32'h1004, 3'd2, 8'd3, 2'b01});
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            vec++; if (obs_addr[i] !== exp_a[i] || obs_last[i] !== (i == 3) || obs_size[i] !== 3'd2) begin
                miss++; $display("FAIL incr_beat%0d: got %h/%b/%0d exp %h/%b/2", i, obs_addr[i], obs_last[i], obs_size[i], exp_a[i], i == 3);
            end
            vec++; if (obs_data[i] !== sent_data[i] || obs_strb[i] !== sent_strb[i]) begin
                miss++; $display("FAIL incr_data%0d: got %h exp %h", i, obs_data[i], sent_data[i]);
            end
        end
        vec++; if (err_sticky !== 1'b0) begin miss++; $display("FAIL incr_err: got %b exp 0", err_sticky); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a[4];
        exp_a = '{32'h2038, 32'h2020, 32'h2028, 32'h2030};
        run_burst(32'h2038, 3'd3, 8'd3, 2'b10, -1, 0, 1'b0);
        vec++; if (timeout || obs_addr.size() != 4) begin miss++; $display("FAIL wrap_beats: got %0d exp 4", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            vec++; if (obs_addr[i] !== exp_a[i] || obs_last[i] !== (i == 3)) begin
                miss++; $display("FAIL wrap_beat%0d: got %h/%b exp %h/%b", i, obs_addr[i], obs_last[i], exp_a[i], i == 3);
            end
        end
        #1;
        vec++; if (u_axi_awready !== 1'b1 || d_axi_wlast !== 1'b0) begin
            miss++; $display("FAIL wrap_idle: got awready %b wlast %b exp 1 0", u_axi_awready, d_axi_wlast);
        end
        vec++; if (err_sticky !== 1'b0) begin miss++; $display("FAIL wrap_err: got %b exp 0", err_sticky); end
    endtask

    task automatic test_fixed_unaligned();
        run_burst(32'h30, 3'd0, 8'd2, 2'b00, -1, 0, 1'b1);
        vec++; if (timeout || obs_addr.size() != 3) begin miss++; $display("FAIL fixed_beats: got %0d exp 3", obs_addr.size()); end
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            vec++; if (obs_addr[i] !== 32'h30 || obs_last[i] !== (i == 2)) begin
                miss++; $display("FAIL fixed_beat%0d: got %h/%b exp 00000030/%b", i, obs_addr[i], obs_last[i], i == 2);
            end
        end
        run_burst(32'h1003, 3'd2, 8'd1, 2'b01, -1, 0, 1'b0);
        vec++; if (timeout || obs_addr.size() != 2) begin miss++; $display("FAIL unal_beats: got %0d exp 2", obs_addr.size()); end
        else if (obs_addr[0] !== 32'h1003 || obs_addr[1] !== 32'h1004) begin
            miss++; $display("FAIL unal_addr: got %h %h exp 00001003 00001004", obs_addr[0], obs_addr[1]);
        end
        vec++; if (err_sticky !== 1'b0) begin miss++; $display("FAIL unal_err: got %b exp 0", err_sticky); end
    endtask

    task automatic test_early_w();
        run_burst(32'h4000, 3'd3, 8'd5, 2'b01, -1, 5, 1'b1);
        vec++; if (stall_viol != 0) begin miss++; $display("FAIL early_stall: got %0d ready-before-AW cycles exp 0", stall_viol); end
        vec++; if (timeout || obs_data.size() != 6) begin miss++; $display("FAIL early_beats: got %0d exp 6", obs_data.size()); end
        for (int i = 0; i < obs_data.size(); i++) begin
            vec++; if (obs_data[i] !== sent_data[i] || obs_addr[i] !== model_addr(32'h4000, 3'd3, 8'd5, 2'b01, i)) begin
                miss++; $display("FAIL early_beat%0d: got %h@%h exp %h@%h", i, obs_data[i], obs_addr[i],
                                 sent_data[i], model_addr(32'h4000, 3'd3, 8'd5, 2'b01, i));
            end
        end
    endtask

    task automatic test_err();
        run_burst(32'h5000, 3'd2, 8'd1, 2'b01, 0, 0, 1'b0);
        vec++; if (timeout || obs_last.size() != 2) begin miss++; $display("FAIL errlast_beats: got %0d exp 2", obs_last.size()); end
        else if (obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin
            miss++; $display("FAIL errlast_wlast: got %b%b exp 01", obs_last[0], obs_last[1]);
        end
        vec++; if (err_sticky !== 1'b1) begin miss++; $display("FAIL errlast_err: got %b exp 1", err_sticky); end
        pulse_reset();
        run_burst(32'h6008, 3'd2, 8'd2, 2'b10, -1, 0, 1'b0);
        vec++; if (timeout || obs_addr.size() != 3) begin miss++; $display("FAIL wrap2_beats: got %0d exp 3", obs_addr.size()); end
        else if (obs_addr[1] !== 32'h600C || obs_addr[2] !== 32'h6010) begin
            miss++; $display("FAIL wrap2_addr: got %h %h exp 0000600c 00006010", obs_addr[1], obs_addr[2]);
        end
        vec++; if (err_sticky !== 1'b1) begin miss++; $display("FAIL wrap2_err: got %b exp 1", err_sticky); end
    endtask

    task automatic test_reset_mid();
        @(negedge aclk);
        u_axi_awaddr = 32'h7000; u_axi_awsize = 3'd3; u_axi_awlen = 8'd7; u_axi_awburst = 2'b01;
        u_axi_awvalid = 1'b1;
        @(negedge aclk);
        u_axi_awvalid = 1'b0;
        u_axi_wvalid = 1'b1; u_axi_wlast = 1'b0;
        @(negedge aclk);
        #1;
        vec++; if (d_axi_waddr !== 32'h7008) begin miss++; $display("FAIL mid_beat2_addr: got %h exp 00007008", d_axi_waddr); end
        #1;
        aresetn = 1'b0;
        #1;
        vec++; if ({d_axi_waddr, d_axi_wsize, err_sticky} !== 36'h0) begin
            miss++; $display("FAIL mid_regs: got %h/%0d/%b exp 0/0/0", d_axi_waddr, d_axi_wsize, err_sticky);
        end
        vec++; if ({u_axi_wready, d_axi_wvalid, d_axi_wlast, u_axi_awready} !== 4'b0001) begin
            miss++; $display("FAIL mid_comb: got %b exp 0001", {u_axi_wready, d_axi_wvalid, d_axi_wlast, u_axi_awready});
        end
        @(negedge aclk);
        u_axi_wvalid = 1'b0;
        aresetn = 1'b1;
        run_burst(32'h8000, 3'd2, 8'd1, 2'b01, -1, 0, 1'b0);
        vec++; if (timeout || obs_addr.size() != 2) begin miss++; $display("FAIL mid_after_beats: got %0d exp 2", obs_addr.size()); end
        else if (obs_addr[0] !== 32'h8000 || obs_addr[1] !== 32'h8004 || obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin
            miss++; $display("FAIL mid_after: got %h/%b %h/%b exp 00008000/0 00008004/1", obs_addr[0], obs_last[0], obs_addr[1], obs_last[1]);
        end
        vec++; if (err_sticky !== 1'b0) begin miss++; $display("FAIL mid_after_err: got %b exp 0", err_sticky); end
    endtask

    task automatic test_back_to_back();
        @(negedge aclk);
        u_axi_awaddr = 32'h9000; u_axi_awsize = 3'd2; u_axi_awlen = 8'd0; u_axi_awburst = 2'b01;
        u_axi_awvalid = 1'b1;
        @(negedge aclk);
        u_axi_awaddr = 32'hA000;
        u_axi_wvalid = 1'b1; u_axi_wlast = 1'b1;
        #1;
        vec++; if ({u_axi_wready, d_axi_wlast, u_axi_awready, d_axi_awvalid} !== 4'b1100) begin
            miss++; $display("FAIL b2b_final: got %b exp 1100", {u_axi_wready, d_axi_wlast, u_axi_awready, d_axi_awvalid});
        end
        @(negedge aclk);
        u_axi_wvalid = 1'b0;
        #1;
        vec++; if (u_axi_awready !== 1'b1 || d_axi_awvalid !== 1'b1) begin
            miss++; $display("FAIL b2b_accept: got %b%b exp 11", u_axi_awready, d_axi_awvalid);
        end
        @(negedge aclk);
        u_axi_awvalid = 1'b0;
        u_axi_wvalid = 1'b1;
        #1;
        vec++; if (d_axi_waddr !== 32'hA000 || d_axi_wlast !== 1'b1 || u_axi_wready !== 1'b1) begin
            miss++; $display("FAIL b2b_second: got %h/%b/%b exp 0000a000/1/1", d_axi_waddr, d_axi_wlast, u_axi_wready);
        end
        @(negedge aclk);
        u_axi_wvalid = 1'b0;
    endtask

    task automatic test_bresp();
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            d_axi_bresp  = 2'($urandom);
            d_axi_bvalid = 1'($urandom);
            u_axi_bready = 1'($urandom);
            #1;
            vec++; if ({u_axi_bresp, u_axi_bvalid, d_axi_bready} !== {d_axi_bresp, d_axi_bvalid, u_axi_bready}) begin
                miss++; $display("FAIL bresp%0d: got %b exp %b", i, {u_axi_bresp, u_axi_bvalid, d_axi_bready},
                                 {d_axi_bresp, d_axi_bvalid, u_axi_bready});
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  len;
        logic [1:0]  burst;
        int          bad;
        for (int n = 0; n < 40; n++) begin
            pulse_reset();
            addr  = $urandom;
            size  = 3'($urandom_range(0, 4));
            burst = 2'($urandom);
            len   = 8'($urandom_range(0, 15));
            if (burst == 2'b10 && $urandom_range(0, 3) != 0) len = 8'((1 << $urandom_range(1, 4)) - 1);
            bad   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(len))) : -1;
            run_burst(addr, size, len, burst, bad, int'($urandom_range(0, 3)), 1'($urandom));
            vec++; if (timeout || obs_addr.size() != int'(len) + 1) begin
                miss++; $display("FAIL rnd%0d_beats: got %0d exp %0d", n, obs_addr.size(), int'(len) + 1);
            end
            for (int i = 0; i < obs_addr.size(); i++) begin
                vec++; if (obs_addr[i] !== model_addr(addr, size, len, burst, i) || obs_last[i] !== (i == int'(len)) ||
                           obs_size[i] !== size || obs_data[i] !== sent_data[i]) begin
                    miss++; $display("FAIL rnd%0d_beat%0d: got %h/%b/%0d exp %h/%b/%0d (a=%h b=%0d l=%0d)", n, i, obs_addr[i],
                                     obs_last[i], obs_size[i], model_addr(addr, size, len, burst, i), i == int'(len), size,
                                     addr, burst, len);
                end
            end
            vec++; if (err_sticky !== model_err(size, len, burst, bad >= 0)) begin
                miss++; $display("FAIL rnd%0d_err: got %b exp %b", n, err_sticky, model_err(size, len, burst, bad >= 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_unaligned();
        test_early_w();
        test_back_to_back();
        test_err();
        test_reset_mid();
        test_bresp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
